// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async_fifo family: occupancy encoding, default
// widths and small sizing helpers.
package async_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned ADDR_WIDTH     = $clog2(DEF_FIFO_DEPTH);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_obuf2.sv
// Two-entry valid/ready output buffer. Head register drives the output
// directly, so out_data is stable while out_vld waits for out_rdy.
module stream_obuf2
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_rdy,
  output occ_e                  occ
);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  pop;

  assign out_vld  = (occ != OCC_EMPTY);
  assign out_data = head;
  assign pop      = out_vld && out_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ  <= OCC_EMPTY;
      head <= '0;
      tail <= '0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (in_vld) begin
            head <= in_data;
            occ  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          case ({in_vld, pop})
            2'b10: begin
              tail <= in_data;
              occ  <= OCC_TWO;
            end
            2'b01: occ  <= OCC_EMPTY;
            2'b11: head <= in_data;
            default: ;
          endcase
        end
        OCC_TWO: begin
          if (pop) begin
            head <= tail;
            if (in_vld) tail <= in_data;
            else        occ  <= OCC_ONE;
          end
        end
        default: occ <= OCC_EMPTY;
      endcase
    end
  end

  // The issue logic upstream must never deliver a word into a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_vld && (occ == OCC_TWO) && !pop));

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side drain for async_fifo: pops the FIFO, absorbs the registered read
// latency and presents a valid/ready stream with burst marking and a word count.
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_cnt
);

  localparam int unsigned      BW        = cnt_bits(BURST_LEN);
  localparam logic [BW-1:0]    BCNT_LAST = BW'(BURST_LEN - 1);

  occ_e          occ;
  logic          inflight;
  logic          xfer;
  logic [BW-1:0] bcnt;
  logic [2:0]    fill;

  assign xfer = m_valid && m_ready;

  // Slots already committed once this cycle's transfer leaves; an in-flight
  // word counts as occupied so the buffer can never be overrun.
  assign fill       = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
  assign fifo_rd_en = rd_rst_n && !fifo_empty && (fill < 3'd2);
  assign m_last     = m_valid && (bcnt == BCNT_LAST);

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      inflight <= 1'b0;
      bcnt     <= '0;
      rd_cnt   <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (xfer) begin
        rd_cnt <= rd_cnt + CNT_WIDTH'(1);
        bcnt   <= (bcnt == BCNT_LAST) ? '0 : bcnt + BW'(1);
      end
    end
  end

  stream_obuf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk      (rd_clk),
    .rst_n    (rd_rst_n),
    .in_vld   (inflight),
    .in_data  (fifo_rd_data),
    .out_vld  (m_valid),
    .out_data (m_data),
    .out_rdy  (m_ready),
    .occ      (occ)
  );

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Scoreboard bench for async_fifo_rd_stream: a queue-based FIFO model feeds the
// DUT, expected words are queued on push and popped by an independent monitor.
module tb_async_fifo_rd_stream;

  localparam int unsigned DW = 4;
  localparam int unsigned BL = 4;
  localparam int unsigned CW = 4;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_empty;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic [CW-1:0] rd_cnt;

  always #5 rd_clk = ~rd_clk;

  async_fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .CNT_WIDTH  (CW)
  ) u_dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .rd_cnt       (rd_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic [DW-1:0] fifo_q[$];
  exp_t          exp_q[$];

  int unsigned n_vec = 0, n_err = 0;
  int unsigned widx = 0, pop_total = 0, xfer_total = 0, exp_cnt = 0;
  int unsigned cyc = 0, first_x = 0, last_x = 0;
  int          occ_m;
  bit            pop_pend = 0, pop_last = 0, hold_pend = 0;
  logic [DW-1:0] hold_data;
  logic          hold_last;
  logic [DW-1:0] w0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Burst position comes from the word's ordinal since the last reset.
  task automatic add_exp(input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.last = ((widx % BL) == BL - 1);
    exp_q.push_back(e);
    widx++;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    add_exp(d);
  endtask

  // One read-clock cycle of the FIFO model: registered read data appears the
  // cycle after a pop; a reset discards everything not still in the FIFO.
  task automatic tick(input bit rdy, input bit stall, input bit rst = 1'b0);
    @(negedge rd_clk);
    if (pop_pend) begin
      pop_pend = 1'b0;
      chk("pop_nonempty", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) fifo_rd_data = fifo_q.pop_front();
    end else begin
      fifo_rd_data = DW'($urandom);
    end
    if (rst) begin
      exp_q.delete();
      widx = 0;
      foreach (fifo_q[i]) add_exp(fifo_q[i]);
    end
    rd_rst_n   = !rst;
    m_ready    = rdy;
    fifo_empty = (fifo_q.size() == 0) || stall;
  endtask

  task automatic drain(input string name, input int unsigned maxc);
    for (int unsigned i = 0; i < maxc && exp_q.size() != 0; i++) tick(1'b1, 1'b0);
    chk(name, exp_q.size(), 0);
    tick(1'b1, 1'b0);
  endtask

  // Monitor: samples pre-edge values on every rising edge.
  always @(posedge rd_clk) begin
    exp_t e;
    cyc++;
    if (!rd_rst_n) begin
      exp_cnt    = 0;
      hold_pend  = 0;
      pop_last   = 0;
      pop_total  = 0;
      xfer_total = 0;
    end else begin
      occ_m = int'(pop_total) - int'(pop_last) - int'(xfer_total);
      chk("valid_vs_occ", m_valid, occ_m != 0);
      chk("occ_bound", (occ_m + int'(pop_last)) <= 2, 1);
      chk("rd_cnt", rd_cnt, exp_cnt % (1 << CW));
      chk("no_pop_when_empty", fifo_rd_en && fifo_empty, 0);
      if (hold_pend) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, hold_data);
        chk("hold_last", m_last, hold_last);
      end
      if (m_valid && m_ready) begin
        chk("spurious_word", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e.data);
          chk("m_last", m_last, e.last);
        end
        xfer_total++;
        exp_cnt++;
        if (xfer_total == 1) first_x = cyc;
        last_x = cyc;
      end
      hold_pend = m_valid && !m_ready;
      hold_data = m_data;
      hold_last = m_last;
      pop_last  = fifo_rd_en;
      if (fifo_rd_en) begin
        pop_total++;
        pop_pend = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rd_rst_n = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_rd_data = '0;
    tick(0, 0, 1); tick(0, 0, 1);
    #1;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_cnt", rd_cnt, 0);

    // Single word: pop in T, valid in T+2.
    tick(1, 0);
    push_word(4'hA);
    tick(1, 0);
    #1 chk("single_rd_en_T", fifo_rd_en, 1);
    tick(1, 0);
    chk("single_valid_T1", m_valid, 0);
    tick(1, 0);
    chk("single_valid_T2", m_valid, 1);
    chk("single_data_T2", m_data, 4'hA);
    tick(1, 0); tick(1, 0); tick(1, 0);
    chk("single_cnt", rd_cnt, 1);
    chk("single_pops", pop_total, 1);

    // Streaming 0..F with no bubbles.
    tick(1, 0, 1); tick(1, 0);
    for (int unsigned i = 0; i < 16; i++) push_word(DW'(i));
    for (int unsigned i = 0; i < 40 && xfer_total < 16; i++) tick(1, 0);
    chk("stream_count", xfer_total, 16);
    chk("stream_span", last_x - first_x, 15);
    tick(1, 0);
    chk("stream_cnt_mod", rd_cnt, 16 % (1 << CW));

    // Backpressure: 8 words, ready low for 10 cycles.
    tick(0, 0, 1); tick(0, 0);
    for (int unsigned i = 0; i < 8; i++) push_word(DW'($urandom));
    w0 = fifo_q[0];
    for (int unsigned i = 0; i < 10; i++) tick(0, 0);
    chk("bp_pops", pop_total, 2);
    chk("bp_fifo_left", fifo_q.size(), 6);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, w0);
    drain("bp_drain", 40);

    // Reset with a full buffer: buffered words are discarded, FIFO words kept.
    tick(0, 0);
    for (int unsigned i = 0; i < 8; i++) push_word(DW'($urandom));
    for (int unsigned i = 0; i < 6; i++) tick(0, 0);
    tick(0, 0, 1);
    #1 chk("rst_gate_rd_en", fifo_rd_en, 0);
    tick(0, 0);
    chk("midrst_valid", m_valid, 0);
    chk("midrst_cnt", rd_cnt, 0);
    chk("midrst_last", m_last, 0);
    drain("midrst_drain", 40);

    // Counter wrap: 17 transfers.
    tick(1, 0, 1); tick(1, 0);
    for (int unsigned i = 0; i < 17; i++) push_word(DW'($urandom));
    drain("wrap_drain", 60);
    chk("wrap_cnt", rd_cnt, 17 % (1 << CW));

    // Ready and empty toggling together, then fully random traffic.
    tick(0, 0, 1); tick(0, 0);
    for (int unsigned i = 0; i < 200; i++) begin
      if (($urandom % 2 == 0) && fifo_q.size() < 12) push_word(DW'($urandom));
      tick(i[0], i[1]);
    end
    for (int unsigned i = 0; i < 400; i++) begin
      if (($urandom % 3 != 0) && fifo_q.size() < 12) push_word(DW'($urandom));
      tick(($urandom % 4) != 0, ($urandom % 4) == 0);
    end
    drain("random_drain", 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
